qspi_arb: RTL and testbench

Arbiter and sequencer that shares the single QSPI memory controller between the instruction cache (line fill) and the data cache (line writeback and fill). It sits between the two caches and the QSPI controller, and replaces the bare `ifetch ? i_tag : d_tag` mux. It grants one transaction at a time and locks a dcache writeback+fill pair together. It also applies round-robin fairness and aborts transactions that never complete.

---
 rtl/qspi_arb.sv | 151 +++++++++++++++
 tb/tb_qspi_arb.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_arb.sv
// Shares one QSPI controller between the icache line fill and the dcache
// writeback+fill pair, with round-robin fairness and a per-transaction watchdog.
module qspi_arb #(
  parameter int PA          = 22,
  parameter int LINE_LENGTH = 4,
  parameter int TIMEOUT     = 255,
  localparam int TW         = PA - $clog2(LINE_LENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [TW-1:0] i_tag,
  input  logic          i_rom,
  output logic          i_done,
  output logic          i_err,
  input  logic          d_pull,
  input  logic          d_push,
  input  logic [TW-1:0] d_tag,
  input  logic [TW-1:0] d_wb_tag,
  input  logic          d_rom,
  output logic          d_done,
  output logic          d_err,
  output logic          q_req,
  output logic          q_write,
  output logic          q_i_d,
  output logic          q_mem,
  output logic [TW-1:0] q_paddr,
  input  logic          q_done,
  output logic          q_abort
);

  typedef enum logic [1:0] {IDLE, I_FILL, D_PUSH, D_PULL} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       last_grant;
  logic       d_any;
  logic       expired;

  assign d_any = d_push | d_pull;

  // q_done arriving in the same cycle as the limit takes priority over the abort
  assign expired = (state != IDLE) && !q_done && (cnt == 8'(TIMEOUT));
  assign q_abort = expired;

  always_comb begin
    i_done = (state == I_FILL) && q_done;
    i_err  = (state == I_FILL) && expired;
    d_done = ((state == D_PULL) && q_done) || ((state == D_PUSH) && q_done && !d_pull);
    d_err  = ((state == D_PUSH) || (state == D_PULL)) && expired;
  end

  always_comb begin
    case (state)
      I_FILL:  q_paddr = i_tag;
      D_PUSH:  q_paddr = d_wb_tag;
      D_PULL:  q_paddr = d_tag;
      default: q_paddr = '0;
    endcase
  end

  // last_grant is 1 when the dcache was granted most recently; it resets to
  // the dcache so the icache wins the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      last_grant <= 1'b1;
      q_req      <= 1'b0;
      q_write    <= 1'b0;
      q_i_d      <= 1'b0;
      q_mem      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (i_req && (!d_any || last_grant)) begin
            state      <= I_FILL;
            last_grant <= 1'b0;
            q_req      <= 1'b1;
            q_write    <= 1'b0;
            q_i_d      <= 1'b1;
            q_mem      <= i_rom;
          end else if (d_any) begin
            last_grant <= 1'b1;
            q_req      <= 1'b1;
            q_i_d      <= 1'b0;
            if (d_push) begin
              state   <= D_PUSH;
              q_write <= 1'b1;
              q_mem   <= 1'b0;
            end else begin
              state   <= D_PULL;
              q_write <= 1'b0;
              q_mem   <= d_rom;
            end
          end
        end
        I_FILL: begin
          if (q_done || expired) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            q_req   <= 1'b0;
            q_write <= 1'b0;
            q_i_d   <= 1'b0;
            q_mem   <= 1'b0;
          end else begin
            cnt   <= cnt + 8'd1;
            q_mem <= i_rom;
          end
        end
        D_PUSH: begin
          // going straight to the fill keeps the icache from slipping in between
          if (q_done && d_pull) begin
            state   <= D_PULL;
            cnt     <= 8'd0;
            q_write <= 1'b0;
            q_mem   <= d_rom;
          end else if (q_done || expired) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            q_req   <= 1'b0;
            q_write <= 1'b0;
            q_i_d   <= 1'b0;
            q_mem   <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        D_PULL: begin
          if (q_done || expired) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            q_req   <= 1'b0;
            q_write <= 1'b0;
            q_i_d   <= 1'b0;
            q_mem   <= 1'b0;
          end else begin
            cnt   <= cnt + 8'd1;
            q_mem <= d_rom;
          end
        end
        default: begin
          state <= IDLE;
          q_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_arb.sv
// Randomised bench for qspi_arb: cache agents and a QSPI responder drive the
// DUT while a scoreboard of expected transaction phases is checked by a monitor.
module tb_qspi_arb;
  localparam int PA          = 22;
  localparam int LINE_LENGTH = 4;
  localparam int TIMEOUT     = 24;
  localparam int TW          = PA - $clog2(LINE_LENGTH);
  localparam int NEVER       = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_rom, i_done, i_err;
  logic [TW-1:0] i_tag;
  logic          d_pull, d_push, d_rom, d_done, d_err;
  logic [TW-1:0] d_tag, d_wb_tag;
  logic          q_req, q_write, q_i_d, q_mem, q_done, q_abort;
  logic [TW-1:0] q_paddr;

  qspi_arb #(.PA(PA), .LINE_LENGTH(LINE_LENGTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_tag(i_tag), .i_rom(i_rom), .i_done(i_done), .i_err(i_err),
    .d_pull(d_pull), .d_push(d_push), .d_tag(d_tag), .d_wb_tag(d_wb_tag),
    .d_rom(d_rom), .d_done(d_done), .d_err(d_err),
    .q_req(q_req), .q_write(q_write), .q_i_d(q_i_d), .q_mem(q_mem),
    .q_paddr(q_paddr), .q_done(q_done), .q_abort(q_abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          write;
    logic          i_d;
    logic          mem;
    logic [TW-1:0] addr;
    logic          last;
  } phase_t;

  phase_t iq[$];
  phase_t dq[$];
  int     lat_plan[$];
  int     cur_lat = 0;
  int     checks = 0;
  int     errors = 0;
  int     i_rate = 0;
  int     d_rate = 0;

  bit     active = 0, chain = 0, gap = 0;
  bit     snap_valid = 0, snap_i = 0, snap_d = 0;
  bit     model_last = 1;
  int     owner = 0, k = 0, exp_owner = 0;
  phase_t cur;
  bit     done_now, err_now;
  logic [4:0] exp_p;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue_i(input logic [TW-1:0] tag, input logic rom);
    phase_t p;
    p = '{write: 1'b0, i_d: 1'b1, mem: rom, addr: tag, last: 1'b1};
    iq.push_back(p);
    i_tag = tag;
    i_rom = rom;
    i_req = 1'b1;
  endtask

  task automatic issue_d(input logic push, input logic pull, input logic [TW-1:0] wb,
                         input logic [TW-1:0] tag, input logic rom);
    phase_t p;
    if (push) begin
      p = '{write: 1'b1, i_d: 1'b0, mem: 1'b0, addr: wb, last: !pull};
      dq.push_back(p);
    end
    if (pull) begin
      p = '{write: 1'b0, i_d: 1'b0, mem: rom, addr: tag, last: 1'b1};
      dq.push_back(p);
    end
    d_wb_tag = wb;
    d_tag    = tag;
    d_rom    = rom;
    d_push   = push;
    d_pull   = pull;
  endtask

  // One cycle of cache-agent behaviour: drop a request once its done/err is seen
  task automatic apply_stimulus();
    bit i_fin, d_fin;
    logic [1:0] kind;
    @(negedge clk);
    i_fin = i_done || i_err;
    d_fin = d_done || d_err;
    @(posedge clk);
    #1;
    if (i_fin) i_req = 1'b0;
    if (d_fin) begin
      d_push = 1'b0;
      d_pull = 1'b0;
    end
    if (!i_req && $urandom_range(99) < i_rate)
      issue_i(TW'($urandom), 1'($urandom));
    if (!d_push && !d_pull && $urandom_range(99) < d_rate) begin
      kind = 2'($urandom_range(3, 1));
      issue_d(kind[0], kind[1], TW'($urandom), TW'($urandom), 1'($urandom));
    end
  endtask

  task automatic drain(input int max_cycles);
    int n;
    logic busy;
    n = 0;
    i_rate = 0;
    d_rate = 0;
    busy = 1'b1;
    while (busy && n < max_cycles) begin
      apply_stimulus();
      n++;
      busy = i_req || d_push || d_pull || q_req || (iq.size() != 0) || (dq.size() != 0);
    end
    check_output("drain_complete", busy, 0);
  endtask

  function automatic int rand_lat();
    int r;
    r = int'($urandom_range(99));
    if (r < 70) return int'($urandom_range(8));
    if (r < 85) return TIMEOUT - int'($urandom_range(1));
    return NEVER;
  endfunction

  // QSPI controller stand-in: picks a latency per phase and pulses q_done
  initial begin
    int rk;
    bit r_active;
    rk = 0;
    r_active = 0;
    q_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset || !q_req) begin
        r_active = 0;
        q_done = 1'b0;
      end else begin
        if (!r_active || q_done) begin
          cur_lat  = (lat_plan.size() != 0) ? lat_plan.pop_front() : rand_lat();
          rk       = 0;
          r_active = 1;
        end
        q_done = (rk == cur_lat);
        rk++;
      end
    end
  end

  task automatic begin_phase(input int who);
    owner  = who;
    k      = 0;
    active = 1;
    if ((who == 0 && iq.size() == 0) || (who == 1 && dq.size() == 0)) begin
      checks++;
      errors++;
      active = 0;
      $display("[TB] FAIL phase_expected actual=grant_to_%0d required=no_grant", who);
    end else if (who == 0) begin
      cur = iq.pop_front();
    end else begin
      cur = dq.pop_front();
    end
  endtask

  // Scoreboard monitor: round-robin grants, phase contents, done/err/abort timing
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (active) begin
          if (owner == 0) iq.push_front(cur);
          else dq.push_front(cur);
        end
        active = 0; chain = 0; gap = 0; snap_valid = 0; model_last = 1;
      end else begin
        if (chain) begin
          chain = 0;
          check_output("pair_q_req_held", q_req, 1);
          begin_phase(1);
        end else if (!active) begin
          if (gap) begin
            check_output("idle_gap", q_req, 0);
            gap = 0;
          end else if (q_req) begin
            if (!snap_valid || !(snap_i || snap_d)) begin
              check_output("spurious_grant", q_req, 0);
            end else begin
              exp_owner  = (snap_i && snap_d) ? (model_last ? 0 : 1) : (snap_i ? 0 : 1);
              model_last = (exp_owner == 1);
              check_output("grant_owner", q_i_d, exp_owner == 0);
              begin_phase(exp_owner);
            end
          end
        end
        if (active) begin
          check_output("phase_fields", {q_req, q_write, q_i_d, q_mem, q_paddr},
                       {1'b1, cur.write, cur.i_d, cur.mem, cur.addr});
          done_now = (k == cur_lat);
          err_now  = !done_now && (k == TIMEOUT);
          exp_p = {owner == 0 && done_now, owner == 0 && err_now,
                   owner == 1 && done_now && cur.last, owner == 1 && err_now, err_now};
          check_output("done_err_abort", {i_done, i_err, d_done, d_err, q_abort}, exp_p);
          k++;
          if (done_now) begin
            active = 0;
            if (cur.last) gap = 1;
            else chain = 1;
          end else if (err_now) begin
            active = 0;
            gap = 1;
            if (!cur.last) void'(dq.pop_front());
          end
        end else begin
          check_output("idle_pulses", {i_done, i_err, d_done, d_err, q_abort}, 0);
          snap_i = i_req;
          snap_d = d_push || d_pull;
          snap_valid = 1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL sim_time_limit actual=running required=finished");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    reset = 1'b0;
    i_req = 1'b0; i_tag = '0; i_rom = 1'b0;
    d_push = 1'b0; d_pull = 1'b0; d_tag = '0; d_wb_tag = '0; d_rom = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_q_outputs", {q_req, q_write, q_i_d, q_mem, q_abort, q_paddr}, 0);
    check_output("reset_pulses", {i_done, i_err, d_done, d_err}, 0);
    reset = 1'b1;

    // lone icache fill, controller answers 20 cycles after q_req
    lat_plan.push_back(20);
    issue_i(20'h12345, 1'b1);
    drain(100);

    // locked writeback+fill pair, icache request arrives mid-sequence
    lat_plan.push_back(5);
    lat_plan.push_back(7);
    lat_plan.push_back(3);
    issue_d(1'b1, 1'b1, 20'h00AA0, 20'h00BB0, 1'b1);
    repeat (4) apply_stimulus();
    issue_i(20'h05555, 1'b0);
    drain(200);

    // both caches keep requesting from reset: grants must alternate I, D, I, D
    reset = 1'b0;
    issue_i(20'h11111, 1'b0);
    issue_d(1'b0, 1'b1, 20'h0, 20'h22222, 1'b0);
    apply_stimulus();
    reset = 1'b1;
    i_rate = 100;
    d_rate = 100;
    repeat (80) apply_stimulus();
    drain(300);

    // watchdog on a lone fill and on the writeback half of a pair
    lat_plan.push_back(NEVER);
    issue_d(1'b0, 1'b1, 20'h0, 20'h33333, 1'b1);
    drain(100);
    lat_plan.push_back(NEVER);
    issue_d(1'b1, 1'b1, 20'h44444, 20'h55555, 1'b0);
    drain(100);

    // q_done exactly at the limit must complete normally
    lat_plan.push_back(TIMEOUT);
    issue_i(20'h66666, 1'b1);
    drain(100);

    // asynchronous reset in the middle of a fill, then a tie after release
    lat_plan.push_back(15);
    issue_i(20'h77777, 1'b1);
    repeat (5) apply_stimulus();
    #1;
    reset = 1'b0;
    #1;
    check_output("async_reset_q", {q_req, q_write, q_i_d, q_mem, q_abort, q_paddr}, 0);
    check_output("async_reset_pulses", {i_done, i_err, d_done, d_err}, 0);
    issue_d(1'b0, 1'b1, 20'h0, 20'h08888, 1'b1);
    repeat (2) apply_stimulus();
    lat_plan.push_back(4);
    lat_plan.push_back(6);
    reset = 1'b1;
    drain(200);

    // random traffic
    i_rate = 30;
    d_rate = 30;
    repeat (1500) apply_stimulus();
    drain(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
